// File: rtl/cardinal_mon_pkg.sv
// Shared types and helpers for the Cardinal run monitor.
package cardinal_mon_pkg;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_DRAIN,
    ST_ISSUE,
    ST_CAPTURE,
    ST_PRESENT,
    ST_DONE
  } mon_state_e;

  // An all-zero instruction word marks the end of a node's program.
  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

  // Widest node mask the search helper accepts.
  localparam int MAX_NODES = 32;

  // Lowest active node index that is >= from; returns nodes when none is left.
  function automatic int next_active(input logic [MAX_NODES-1:0] mask,
                                     input int from,
                                     input int nodes);
    int r;
    r = nodes;
    for (int i = MAX_NODES - 1; i >= 0; i--) begin
      if (i >= from && i < nodes && mask[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/run_counter.sv
// Per-node halt detector and saturating run-cycle counter.
module run_counter
  import cardinal_mon_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               active_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic               halted_o,
  output logic [CNT_W-1:0]   count_o
);

  logic             halted_q, halted_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Inactive nodes halt immediately; a NOP halts without counting that cycle.
  always_comb begin
    halted_d = halted_q;
    count_d  = count_q;
    if (!halted_q) begin
      if (!active_i || instr_i == INSTR_W'(INSTR_NOP)) begin
        halted_d = 1'b1;
      end else if (count_q != '1) begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  // State register; the halted flag is sticky until reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      halted_q <= halted_d;
      count_q  <= count_d;
    end
  end

  assign halted_o = halted_q;
  assign count_o  = count_q;

endmodule

// File: rtl/cardinal_run_monitor.sv
// Run monitor and data-memory dump sequencer for a Cardinal node array.
module cardinal_run_monitor
  import cardinal_mon_pkg::*;
#(
  parameter int NODES        = 4,
  parameter int INSTR_W      = 32,
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 64,
  parameter int CNT_W        = 32,
  parameter int DUMP_DEPTH   = 128,
  parameter int DRAIN_CYCLES = 5,
  localparam int NODE_W      = (NODES > 1) ? $clog2(NODES) : 1
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [NODES-1:0]         Node_Active,
  input  logic [NODES*INSTR_W-1:0] Instruction,
  output logic [NODES-1:0]         Halted,
  output logic [NODES*CNT_W-1:0]   Cycle_Count,
  output logic [NODES-1:0]         Dmem_En,
  output logic [ADDR_W-1:0]        Dmem_Addr,
  input  logic [NODES*DATA_W-1:0]  Dmem_Data,
  output logic                     Dump_Valid,
  input  logic                     Dump_Ready,
  output logic [NODE_W-1:0]        Dump_Node,
  output logic [ADDR_W-1:0]        Dump_Addr,
  output logic [DATA_W-1:0]        Dump_Data,
  output logic                     Done
);

  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  mon_state_e          state_q, state_d;
  logic [NODES-1:0]    active_q;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic [NODE_W-1:0]   node_q, node_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                valid_q, valid_d;
  logic [NODE_W-1:0]   dnode_q, dnode_d;
  logic [ADDR_W-1:0]   daddr_q, daddr_d;
  logic [DATA_W-1:0]   ddata_q, ddata_d;
  logic                done_q, done_d;
  int                  first_node;
  int                  later_node;

  for (genvar k = 0; k < NODES; k++) begin : g_node
    run_counter #(
      .INSTR_W (INSTR_W),
      .CNT_W   (CNT_W)
    ) u_cnt (
      .clk_i    (Clock),
      .rst_i    (Reset),
      .active_i (active_q[k]),
      .instr_i  (Instruction[k*INSTR_W +: INSTR_W]),
      .halted_o (Halted[k]),
      .count_o  (Cycle_Count[k*CNT_W +: CNT_W])
    );
  end

  assign first_node = next_active(MAX_NODES'(active_q), 0, NODES);
  assign later_node = next_active(MAX_NODES'(active_q), int'(node_q) + 1, NODES);

  // The active mask is captured only while reset is held.
  always_ff @(posedge Clock) begin
    if (Reset) active_q <= Node_Active;
  end

  // Sequencer: wait for all halts, drain, then issue/capture/present each word.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    node_d  = node_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    dnode_d = dnode_q;
    daddr_d = daddr_q;
    ddata_d = ddata_q;
    done_d  = done_q;
    case (state_q)
      ST_RUN: begin
        if (&Halted) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
          if (first_node >= NODES) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ISSUE;
            node_d  = NODE_W'(first_node);
            addr_d  = '0;
          end
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      ST_ISSUE: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        ddata_d = Dmem_Data[int'(node_q)*DATA_W +: DATA_W];
        dnode_d = node_q;
        daddr_d = addr_q;
        valid_d = 1'b1;
        state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (Dump_Ready) begin
          valid_d = 1'b0;
          if (addr_q != ADDR_W'(DUMP_DEPTH - 1)) begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = ST_ISSUE;
          end else if (later_node >= NODES) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            node_d  = NODE_W'(later_node);
            addr_d  = '0;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_DONE: done_d = 1'b1;
      default: state_d = ST_RUN;
    endcase
  end

  // Sequencer and output registers; reset abandons any dump in progress.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_RUN;
      drain_q <= '0;
      node_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      dnode_q <= '0;
      daddr_q <= '0;
      ddata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      node_q  <= node_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      dnode_q <= dnode_d;
      daddr_q <= daddr_d;
      ddata_q <= ddata_d;
      done_q  <= done_d;
    end
  end

  // Read enable is a one-cycle strobe toward the node being dumped.
  always_comb begin
    Dmem_En = '0;
    if (state_q == ST_ISSUE) Dmem_En[node_q] = 1'b1;
  end

  assign Dmem_Addr  = addr_q;
  assign Dump_Valid = valid_q;
  assign Dump_Node  = dnode_q;
  assign Dump_Addr  = daddr_q;
  assign Dump_Data  = ddata_q;
  assign Done       = done_q;

endmodule

// File: tb/tb_cardinal_run_monitor.sv
// Directed bench for cardinal_run_monitor with a 1-cycle-latency dmem model.
module tb_cardinal_run_monitor;

  localparam int DEPTH = 128;

  logic         Clock = 1'b0;
  logic         Reset;
  logic [3:0]   Node_Active;
  logic [127:0] Instruction;
  logic [3:0]   Halted;
  logic [127:0] Cycle_Count;
  logic [3:0]   Dmem_En;
  logic [7:0]   Dmem_Addr;
  logic [255:0] Dmem_Data;
  logic         Dump_Valid;
  logic         Dump_Ready;
  logic [1:0]   Dump_Node;
  logic [7:0]   Dump_Addr;
  logic [63:0]  Dump_Data;
  logic         Done;

  logic         Reset2;
  logic [1:0]   Node_Active2;
  logic [63:0]  Instruction2;
  logic [1:0]   Halted2;
  logic [7:0]   Cycle_Count2;
  logic [1:0]   Dmem_En2;
  logic [7:0]   Dmem_Addr2;
  logic [127:0] Dmem_Data2;
  logic         Dump_Valid2;
  logic         Dump_Ready2;
  logic [0:0]   Dump_Node2;
  logic [7:0]   Dump_Addr2;
  logic [63:0]  Dump_Data2;
  logic         Done2;

  int checks;
  int errors;
  int nop_at[4];

  always #5 Clock = ~Clock;

  cardinal_run_monitor dut (
    .Clock(Clock), .Reset(Reset), .Node_Active(Node_Active), .Instruction(Instruction),
    .Halted(Halted), .Cycle_Count(Cycle_Count), .Dmem_En(Dmem_En), .Dmem_Addr(Dmem_Addr),
    .Dmem_Data(Dmem_Data), .Dump_Valid(Dump_Valid), .Dump_Ready(Dump_Ready),
    .Dump_Node(Dump_Node), .Dump_Addr(Dump_Addr), .Dump_Data(Dump_Data), .Done(Done)
  );

  cardinal_run_monitor #(
    .NODES(2), .CNT_W(4), .DUMP_DEPTH(2), .DRAIN_CYCLES(1)
  ) dut_sat (
    .Clock(Clock), .Reset(Reset2), .Node_Active(Node_Active2), .Instruction(Instruction2),
    .Halted(Halted2), .Cycle_Count(Cycle_Count2), .Dmem_En(Dmem_En2), .Dmem_Addr(Dmem_Addr2),
    .Dmem_Data(Dmem_Data2), .Dump_Valid(Dump_Valid2), .Dump_Ready(Dump_Ready2),
    .Dump_Node(Dump_Node2), .Dump_Addr(Dump_Addr2), .Dump_Data(Dump_Data2), .Done(Done2)
  );

  function automatic logic [63:0] word_of(input int k, input logic [7:0] a);
    return 64'hC0DE_0000_0000_0000 | (64'(k) << 8) | {56'd0, a};
  endfunction

  // Synchronous-read data memories: data appears the edge after the enable.
  always @(posedge Clock) begin
    for (int k = 0; k < 4; k++)
      if (Dmem_En[k]) Dmem_Data[k*64 +: 64] <= word_of(k, Dmem_Addr);
  end

  task automatic step;
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] mask);
    Reset = 1'b1;
    Node_Active = mask;
    Dump_Ready = 1'b0;
    Instruction = {4{32'h0000_0013}};
    step;
    step;
    Reset = 1'b0;
  endtask

  task automatic set_instr(input int c);
    for (int k = 0; k < 4; k++) begin
      if (c < nop_at[k])       Instruction[k*32 +: 32] = 32'h0000_0013 + 32'(c);
      else if (c == nop_at[k]) Instruction[k*32 +: 32] = 32'h0000_0000;
      else                     Instruction[k*32 +: 32] = 32'hDEAD_0000 + 32'(k);
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++; if (Halted !== 4'b0) begin errors++; $display("FAIL %s_halted: got %b want 0000", tag, Halted); end
    checks++; if (Cycle_Count !== 128'd0) begin errors++; $display("FAIL %s_count: got %h want 0", tag, Cycle_Count); end
    checks++; if (Dmem_En !== 4'b0) begin errors++; $display("FAIL %s_dmem_en: got %b want 0000", tag, Dmem_En); end
    checks++; if (Dmem_Addr !== 8'd0) begin errors++; $display("FAIL %s_dmem_addr: got %0d want 0", tag, Dmem_Addr); end
    checks++; if (Dump_Valid !== 1'b0) begin errors++; $display("FAIL %s_valid: got %b want 0", tag, Dump_Valid); end
    checks++; if (Dump_Node !== 2'd0) begin errors++; $display("FAIL %s_dump_node: got %0d want 0", tag, Dump_Node); end
    checks++; if (Dump_Addr !== 8'd0) begin errors++; $display("FAIL %s_dump_addr: got %0d want 0", tag, Dump_Addr); end
    checks++; if (Dump_Data !== 64'd0) begin errors++; $display("FAIL %s_dump_data: got %h want 0", tag, Dump_Data); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL %s_done: got %b want 0", tag, Done); end
  endtask

  // Consumes a full dump, checking order, data, pacing, handshake stability and Done timing.
  task automatic dump_run(input bit rnd, input logic [3:0] mask, input int budget);
    int exp_node, exp_addr, words, total, last_hs, done_cyc, bad_en, unstable;
    bit hold;
    logic [1:0] h_node;
    logic [7:0] h_addr;
    logic [63:0] h_data;
    total = $countones(mask) * DEPTH;
    exp_node = 0;
    while (exp_node < 4 && !mask[exp_node]) exp_node++;
    exp_addr = 0; words = 0; last_hs = -1; done_cyc = -1; bad_en = 0; unstable = 0; hold = 1'b0;
    h_node = '0; h_addr = '0; h_data = '0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if ((Dmem_En & ~mask) != 4'b0 || $countones(Dmem_En) > 1) bad_en++;
      if (hold && (Dump_Valid !== 1'b1 || Dump_Node !== h_node || Dump_Addr !== h_addr || Dump_Data !== h_data)) unstable++;
      if (Done === 1'b1) begin done_cyc = cyc; break; end
      Dump_Ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (Dump_Valid === 1'b1 && Dump_Ready) begin
        checks++;
        if (Dump_Node !== 2'(exp_node) || Dump_Addr !== 8'(exp_addr) || Dump_Data !== word_of(exp_node, 8'(exp_addr))) begin
          errors++;
          $display("FAIL dump_word: got node %0d addr %0d data %h want node %0d addr %0d data %h",
                   Dump_Node, Dump_Addr, Dump_Data, exp_node, exp_addr, word_of(exp_node, 8'(exp_addr)));
        end
        if (!rnd && last_hs >= 0) begin
          checks++;
          if (cyc - last_hs != 3) begin errors++; $display("FAIL dump_gap: got %0d cycles want 3", cyc - last_hs); end
        end
        last_hs = cyc;
        words++;
        if (exp_addr < DEPTH - 1) exp_addr++;
        else begin
          exp_addr = 0;
          exp_node++;
          while (exp_node < 4 && !mask[exp_node]) exp_node++;
        end
      end
      hold = (Dump_Valid === 1'b1) && !Dump_Ready;
      h_node = Dump_Node; h_addr = Dump_Addr; h_data = Dump_Data;
      step;
    end
    checks++; if (words != total) begin errors++; $display("FAIL dump_words: got %0d want %0d", words, total); end
    checks++; if (done_cyc != last_hs + 1) begin errors++; $display("FAIL done_timing: got cycle %0d want %0d", done_cyc, last_hs + 1); end
    checks++; if (Dump_Valid !== 1'b0) begin errors++; $display("FAIL done_valid: got %b want 0", Dump_Valid); end
    checks++; if (bad_en != 0) begin errors++; $display("FAIL dmem_en_mask: got %0d bad cycles want 0", bad_en); end
    checks++; if (unstable != 0) begin errors++; $display("FAIL hold_stable: got %0d unstable cycles want 0", unstable); end
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    Node_Active = 4'b0101;
    Dump_Ready = 1'b1;
    Instruction = '0;
    step;
    step;
    check_reset_values("reset");
  endtask

  task automatic test_counts;
    nop_at = '{11, 12, 13, 14};
    do_reset(4'hF);
    for (int c = 1; c <= 14; c++) begin
      set_instr(c);
      step;
      if (c == 1) begin
        checks++; if (Cycle_Count[31:0] !== 32'd1) begin errors++; $display("FAIL first_count: got %0d want 1", Cycle_Count[31:0]); end
      end
      if (c == 13) begin
        checks++; if (Halted !== 4'b0111) begin errors++; $display("FAIL halt_order: got %b want 0111", Halted); end
      end
    end
    checks++; if (Halted !== 4'hF) begin errors++; $display("FAIL all_halted: got %b want 1111", Halted); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (Cycle_Count[k*32 +: 32] !== 32'(10 + k)) begin
        errors++; $display("FAIL run_count%0d: got %0d want %0d", k, Cycle_Count[k*32 +: 32], 10 + k);
      end
    end
    for (int c = 15; c <= 20; c++) begin
      set_instr(c);
      step;
      if (c == 19) begin
        checks++; if (Dmem_En !== 4'b0000) begin errors++; $display("FAIL drain_len_en: got %b want 0000", Dmem_En); end
      end
    end
    checks++; if (Dmem_En !== 4'b0001 || Dmem_Addr !== 8'd0) begin errors++; $display("FAIL first_issue: got en %b addr %0d want 0001 0", Dmem_En, Dmem_Addr); end
    checks++; if (Cycle_Count[127:96] !== 32'd13) begin errors++; $display("FAIL count_frozen: got %0d want 13", Cycle_Count[127:96]); end
    step;
    checks++; if (Dump_Valid !== 1'b0) begin errors++; $display("FAIL capture_valid: got %b want 0", Dump_Valid); end
    step;
    checks++; if (Dump_Valid !== 1'b1 || Dump_Data !== word_of(0, 8'd0)) begin errors++; $display("FAIL first_word: got v %b data %h want 1 %h", Dump_Valid, Dump_Data, word_of(0, 8'd0)); end
  endtask

  task automatic test_reset_mid_dump;
    bit found;
    found = 1'b0;
    Dump_Ready = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (Dump_Valid === 1'b1 && Dump_Node === 2'd1 && Dump_Addr === 8'd37) begin found = 1'b1; break; end
      step;
    end
    checks++; if (!found || Dump_Data !== word_of(1, 8'd37)) begin errors++; $display("FAIL reach_n1a37: got found %b data %h want 1 %h", found, Dump_Data, word_of(1, 8'd37)); end
    Reset = 1'b1;
    step;
    check_reset_values("midreset");
  endtask

  task automatic test_dump_order;
    nop_at = '{3, 100, 5, 100};
    do_reset(4'b0101);
    for (int c = 1; c <= 6; c++) begin
      set_instr(c);
      step;
      if (c == 1) begin
        checks++; if (Halted !== 4'b1010) begin errors++; $display("FAIL inactive_halted: got %b want 1010", Halted); end
      end
    end
    checks++;
    if (Cycle_Count !== {32'd0, 32'd4, 32'd0, 32'd2}) begin
      errors++; $display("FAIL mask_counts: got %h want node counts 2,0,4,0", Cycle_Count);
    end
    dump_run(1'b0, 4'b0101, 1200);
  endtask

  task automatic test_ready_toggle;
    nop_at = '{2, 2, 2, 2};
    do_reset(4'b1011);
    for (int c = 1; c <= 3; c++) begin
      set_instr(c);
      step;
    end
    checks++;
    if (Cycle_Count !== {32'd1, 32'd0, 32'd1, 32'd1}) begin
      errors++; $display("FAIL toggle_counts: got %h want node counts 1,1,0,1", Cycle_Count);
    end
    dump_run(1'b1, 4'b1011, 4000);
  endtask

  task automatic test_all_inactive;
    bit saw_valid, saw_en;
    saw_valid = 1'b0;
    saw_en = 1'b0;
    do_reset(4'b0000);
    for (int c = 1; c <= 10; c++) begin
      step;
      if (Dump_Valid !== 1'b0) saw_valid = 1'b1;
      if (Dmem_En !== 4'b0) saw_en = 1'b1;
      if (c == 1) begin
        checks++; if (Halted !== 4'hF) begin errors++; $display("FAIL idle_halted: got %b want 1111", Halted); end
      end
      if (c == 6) begin
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL idle_done_early: got %b want 0", Done); end
      end
      if (c == 7) begin
        checks++; if (Done !== 1'b1) begin errors++; $display("FAIL idle_done: got %b want 1", Done); end
      end
    end
    checks++; if (saw_valid || saw_en) begin errors++; $display("FAIL idle_no_dump: got valid %b en %b want 0 0", saw_valid, saw_en); end
    checks++; if (Cycle_Count !== 128'd0) begin errors++; $display("FAIL idle_counts: got %h want 0", Cycle_Count); end
  endtask

  task automatic test_saturate;
    Reset2 = 1'b1;
    Node_Active2 = 2'b11;
    Instruction2 = {2{32'h0000_0013}};
    step;
    step;
    Reset2 = 1'b0;
    for (int c = 1; c <= 41; c++) begin
      Instruction2[31:0]  = (c == 40) ? 32'h0 : 32'h0000_0013;
      Instruction2[63:32] = (c == 9) ? 32'h0 : 32'h0000_0033;
      step;
      if (c == 14) begin
        checks++; if (Cycle_Count2[3:0] !== 4'd14) begin errors++; $display("FAIL sat_pre: got %0d want 14", Cycle_Count2[3:0]); end
      end
      if (c == 17) begin
        checks++; if (Cycle_Count2[3:0] !== 4'd15 || Halted2 !== 2'b10) begin errors++; $display("FAIL sat_hold: got %0d halted %b want 15 10", Cycle_Count2[3:0], Halted2); end
      end
    end
    checks++; if (Halted2 !== 2'b11) begin errors++; $display("FAIL sat_halted: got %b want 11", Halted2); end
    checks++; if (Cycle_Count2 !== {4'd8, 4'd15}) begin errors++; $display("FAIL sat_counts: got %h want 8f", Cycle_Count2); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    Reset = 1'b1;
    Node_Active = '0;
    Instruction = '0;
    Dump_Ready = 1'b0;
    Reset2 = 1'b1;
    Node_Active2 = '0;
    Instruction2 = '0;
    Dmem_Data2 = '0;
    Dump_Ready2 = 1'b1;
    test_reset;
    test_counts;
    test_reset_mid_dump;
    test_dump_order;
    test_ready_toggle;
    test_all_inactive;
    test_saturate;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cardinal_run_monitor.md
# cardinal_run_monitor

Synthesizable run-monitor and dump sequencer for multi-node Cardinal processor arrays. It sits beside NODES processor/imem/dmem triples. Per node, it counts execution cycles until that node fetches the terminating NOP (32'h00000000). Once every active node has halted, it waits a pipeline-drain interval, then streams each active node's data memory out over a valid/ready port. It replaces bench-only completion detection and memory dumping with hardware usable in both synthesized and gate-level runs.

## Interface
Parameters:
- NODES, 4: number of processor nodes monitored.
- INSTR_W, 32: instruction width.
- ADDR_W, 8: data-memory address width.
- DATA_W, 64: data-memory word width.
- CNT_W, 32: cycle-counter width.
- DUMP_DEPTH, 128: words dumped per node, addresses 0..DUMP_DEPTH-1; must be ≤ 2^ADDR_W.
- DRAIN_CYCLES, 5: idle cycles between all-halted and first dump read; must be ≥ 1.

Ports:
- Clock  in  1  sole clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Node_Active  in  NODES  bit k enables node k; sampled only while Reset=1.
- Instruction  in  NODES*INSTR_W  fetched instruction per node; node k occupies slice k.
- Halted  out  NODES  bit k sticky-high once node k fetched the NOP.
- Cycle_Count  out  NODES*CNT_W  per-node run cycle count; slice k is node k.
- Dmem_En  out  NODES  one-hot dmem read enable toward the node being dumped.
- Dmem_Addr  out  ADDR_W  dmem read address, shared by all nodes.
- Dmem_Data  in  NODES*DATA_W  dmem read data per node.
- Dump_Valid  out  1  dump word available.
- Dump_Ready  in  1  consumer accepts the word.
- Dump_Node  out  max(1,$clog2(NODES))  node index of the current dump word.
- Dump_Addr  out  ADDR_W  address of the current dump word.
- Dump_Data  out  DATA_W  dump word.
- Done  out  1  sticky-high after the last dump handshake.

## Operation
- Reset=1 forces the following values: Halted=0, Cycle_Count=0, Dmem_En=0, Dmem_Addr=0, Dump_Valid=0, Dump_Node=0, Dump_Addr=0, Dump_Data=0, Done=0, FSM=RUN. The active mask is latched from Node_Active.
- Inactive node: Halted reads 1 and its count stays 0 from the first post-reset cycle. It is skipped by the dump.
- Active node k, running: on each edge with Reset=0, the count increments by 1, saturating at 2^CNT_W−1 (no wrap).
- Active node k, NOP observed: on an edge where its Instruction slice is 0, Halted[k] is set and the count does not increment that cycle. A NOP in the first post-reset cycle therefore yields count 0.
- After Halted[k] is set, later Instruction values for node k are ignored.
- FSM states and transitions:
  - RUN→DRAIN when all Halted bits are 1.
  - DRAIN: counts DRAIN_CYCLES cycles, then goes to ISSUE with node = lowest active index and addr = 0.
  - ISSUE: drives Dmem_En[node]=1 and Dmem_Addr=addr for one cycle, then goes to CAPTURE.
  - CAPTURE: registers Dmem_Data[node] into Dump_Data, loads Dump_Node/Dump_Addr, sets Dump_Valid=1, then goes to PRESENT.
  - PRESENT: holds all Dump_* outputs stable until Dump_Valid && Dump_Ready. On that handshake, Dump_Valid drops and the FSM advances:
    - addr+1 if addr < DUMP_DEPTH−1, then to ISSUE;
    - otherwise to the next higher active node at addr 0, then to ISSUE;
    - if no active node remains, to DONE.
  - DONE: Done=1 and holds until Reset.
- All nodes inactive: RUN→DRAIN→DONE with no reads issued.
- Reset asserted in any state: the next edge restores reset values. A partial dump is abandoned.

## Timing
- dmem read latency is fixed at 1 cycle: the address is issued in ISSUE and the data is valid on the following edge (CAPTURE).
- Dump_Valid rises 2 cycles after ISSUE entry.
- Maximum dump throughput is 1 word per 3 cycles, achieved with Dump_Ready held at 1.
- Halted[k] and the frozen count are visible on the edge after the NOP cycle.
- DRAIN entry occurs 1 cycle after the final Halted bit rises.
- Done rises on the edge after the last handshake.
- Dmem_En is 0 outside ISSUE.

## Structure
- Package cardinal_mon_pkg holds:
  - the state enum (RUN, DRAIN, ISSUE, CAPTURE, PRESENT, DONE);
  - the constant INSTR_NOP = 0;
  - a function returning the next active node index.
- One sub-module, run_counter, instantiated NODES times, holds the halted flag and the saturating counter.
- The top level holds the FSM, drain counter, node/address pointers and output registers.

## Test plan
- NODES=4, all active, node k fetches the NOP after 10+k cycles → counts 10, 11, 12, 13. DRAIN lasts exactly 5 cycles after node 3 halts.
- Node active mask 4'b0101, Dump_Ready=1, each dmem word = {node, addr} → 256 words in order: node0 addrs 0..127, then node2 addrs 0..127. Done after the 256th handshake; Dmem_En never 4'b0010 or 4'b1000.
- Dump_Ready toggling pseudo-randomly → no word lost or duplicated; Dump_Data/Dump_Addr stable while Valid && !Ready.
- CNT_W=4, NOP at cycle 40 → count saturates at 15.
- Reset pulsed mid-dump at node1 addr 37 → all outputs return to reset values on the next edge; the rerun restarts from RUN with counts at 0.
- Node_Active=0 → Done asserted 1+DRAIN_CYCLES+1 cycles after reset release; no Dump_Valid ever.
